// File: rtl/ray_plane_hit.sv
// ray_plane_hit: pops one ray, intersects it with the captured plane, pushes {miss, p_hit} downstream.
// Latency: write 38 cycles after the pop on a hit, 5 cycles on a miss; one ray in flight at a time.
// Backpressure: waits in WRITE with p_hit/miss stable while fifo_out_full; no upstream pop until written.
module ray_plane_hit #(
  parameter int Q_BITS = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [191:0]        ray,
  input  logic                fifo_in_empty,
  output logic                fifo_in_rd_en,
  input  logic [2:0][31:0]    normal,
  input  logic [2:0][31:0]    v0,
  output logic [95:0]         p_hit,
  output logic                miss,
  input  logic                fifo_out_full,
  output logic                fifo_out_wr_en
);

  // Divider datapath width: must hold |num| << Q_BITS and |den| << 31 without overflow.
  localparam int DW = ((67 + Q_BITS > 97) ? 67 + Q_BITS : 97) + 1;

  typedef enum logic [2:0] {IDLE, DOT, CHECK, DIV, MUL, WRITE} state_t;

  state_t               state;
  logic [2:0][31:0]     o_r, d_r, n_r, v_r;
  logic [1:0]           axis;
  logic [4:0]           div_cnt;
  logic signed [66:0]   num;
  logic signed [65:0]   den;
  logic [DW-1:0]        rem;
  logic [DW-1:0]        dsh;
  logic [31:0]          quot;

  logic [31:0]          n_i, v_i, o_i, d_i;
  logic signed [63:0]   p_nv, p_no, p_nd;
  logic signed [66:0]   num_nxt;
  logic signed [65:0]   den_nxt;

  logic [66:0]          num_abs;
  logic [65:0]          den_abs;
  logic [DW-1:0]        num_sh;
  logic [DW-1:0]        den_sh;
  logic                 miss_c;

  logic signed [63:0]   o64   [3];
  logic signed [63:0]   mprod [3];
  logic [2:0][31:0]     p_calc;

  // One axis of both dot products per cycle; products are exact 64-bit signed.
  always_comb begin
    n_i = n_r[axis];
    v_i = v_r[axis];
    o_i = o_r[axis];
    d_i = d_r[axis];
    p_nv = $signed({{32{n_i[31]}}, n_i}) * $signed({{32{v_i[31]}}, v_i});
    p_no = $signed({{32{n_i[31]}}, n_i}) * $signed({{32{o_i[31]}}, o_i});
    p_nd = $signed({{32{n_i[31]}}, n_i}) * $signed({{32{d_i[31]}}, d_i});
    num_nxt = num + $signed({{3{p_nv[63]}}, p_nv}) - $signed({{3{p_no[63]}}, p_no});
    den_nxt = den + $signed({{2{p_nd[63]}}, p_nd});
  end

  // Miss classification: parallel ray, plane behind origin, or |t| too large for 31 bits.
  always_comb begin
    num_abs = num[66] ? 67'(-num) : 67'(num);
    den_abs = den[65] ? 66'(-den) : 66'(den);
    num_sh  = {{(DW-67){1'b0}}, num_abs} << Q_BITS;
    den_sh  = {{(DW-66){1'b0}}, den_abs} << 31;
    miss_c  = (den == '0)
           || ((num != '0) && (num[66] != den[65]))
           || (num_sh >= den_sh);
  end

  // p_i = o_i + ((t * d_i) >>> Q_BITS), truncated to 32 bits; t is non-negative.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      o64[i]    = $signed({{32{o_r[i][31]}}, o_r[i]});
      mprod[i]  = $signed({32'b0, quot}) * $signed({{32{d_r[i][31]}}, d_r[i]});
      p_calc[i] = 32'(o64[i] + (mprod[i] >>> Q_BITS));
    end
  end

  assign fifo_in_rd_en  = !reset && (state == IDLE)  && !fifo_in_empty;
  assign fifo_out_wr_en = !reset && (state == WRITE) && !fifo_out_full;

  // Sequencer: capture, dot products, classify, serial divide, scale, hand off.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      p_hit   <= '0;
      miss    <= 1'b0;
      axis    <= '0;
      div_cnt <= '0;
      num     <= '0;
      den     <= '0;
      rem     <= '0;
      dsh     <= '0;
      quot    <= '0;
      o_r     <= '0;
      d_r     <= '0;
      n_r     <= '0;
      v_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_in_empty) begin
            o_r   <= ray[95:0];
            d_r   <= ray[191:96];
            n_r   <= normal;
            v_r   <= v0;
            num   <= '0;
            den   <= '0;
            axis  <= '0;
            state <= DOT;
          end
        end
        DOT: begin
          num  <= num_nxt;
          den  <= den_nxt;
          axis <= axis + 2'd1;
          if (axis == 2'd2) state <= CHECK;
        end
        CHECK: begin
          if (miss_c) begin
            p_hit <= '0;
            miss  <= 1'b1;
            state <= WRITE;
          end else begin
            rem     <= num_sh;
            dsh     <= den_sh;
            quot    <= '0;
            div_cnt <= '0;
            state   <= DIV;
          end
        end
        DIV: begin
          // Restoring step: the shifted divisor walks down from |den| << 31 to |den|.
          if (rem >= dsh) begin
            rem  <= rem - dsh;
            quot <= {quot[30:0], 1'b1};
          end else begin
            quot <= {quot[30:0], 1'b0};
          end
          dsh     <= dsh >> 1;
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == 5'd31) state <= MUL;
        end
        MUL: begin
          p_hit <= p_calc;
          miss  <= 1'b0;
          state <= WRITE;
        end
        WRITE: begin
          if (!fifo_out_full) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_plane_hit.sv
// tb_ray_plane_hit: directed and streamed rays against hand values and a wide-integer reference.
// Latency: checks 38-cycle hit and 5-cycle miss pop-to-write distances.
// Backpressure: holds fifo_out_full and checks stall, single write on release, no early pop.
module tb_ray_plane_hit;
  localparam int Q = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic [191:0]     ray;
  logic             fifo_in_empty;
  logic             fifo_in_rd_en;
  logic [2:0][31:0] normal;
  logic [2:0][31:0] v0;
  logic [95:0]      p_hit;
  logic             miss;
  logic             fifo_out_full;
  logic             fifo_out_wr_en;

  typedef struct packed {
    logic [191:0] ray;
    logic [95:0]  n;
    logic [95:0]  v;
  } job_t;

  job_t         in_q [$];
  logic [96:0]  exp_q [$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, pops = 0, writes = 0, last_pop = 0, last_wr = 0, pop_gap = 0, extra = 0;
  logic        s_wr, s_rd, s_m;
  logic [95:0] s_p;

  ray_plane_hit #(.Q_BITS(Q)) dut (
    .clock          (clock),
    .reset          (reset),
    .ray            (ray),
    .fifo_in_empty  (fifo_in_empty),
    .fifo_in_rd_en  (fifo_in_rd_en),
    .normal         (normal),
    .v0             (v0),
    .p_hit          (p_hit),
    .miss           (miss),
    .fifo_out_full  (fifo_out_full),
    .fifo_out_wr_en (fifo_out_wr_en)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [95:0] v3(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {z, y, x};
  endfunction

  // Reference: exact wide integer arithmetic with a real divide.
  function automatic logic [96:0] model(input logic [95:0] o, input logic [95:0] d,
                                        input logic [95:0] n, input logic [95:0] v);
    logic signed [127:0] num, den, an, ad, t, pr, oi, di, ni, vi;
    logic [95:0] p;
    num = '0;
    den = '0;
    p   = '0;
    for (int i = 0; i < 3; i++) begin
      ni  = $signed(n[i*32 +: 32]);
      vi  = $signed(v[i*32 +: 32]);
      oi  = $signed(o[i*32 +: 32]);
      di  = $signed(d[i*32 +: 32]);
      num = num + ni * vi - ni * oi;
      den = den + ni * di;
    end
    an = (num < 0) ? -num : num;
    ad = (den < 0) ? -den : den;
    if (den == 0 || (num != 0 && ((num < 0) != (den < 0))) || ((an <<< Q) >= (ad <<< 31)))
      return {1'b1, 96'b0};
    t = (an <<< Q) / ad;
    for (int i = 0; i < 3; i++) begin
      oi = $signed(o[i*32 +: 32]);
      di = $signed(d[i*32 +: 32]);
      pr = (t * di) >>> Q;
      p[i*32 +: 32] = 32'(oi + pr);
    end
    return {1'b0, p};
  endfunction

  function automatic logic [31:0] rc();
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1:       return $urandom;
      default: return $urandom_range(0, 2097151) - 32'd1048576;
    endcase
  endfunction

  task automatic drive_in();
    if (in_q.size() != 0) begin
      fifo_in_empty = 1'b0;
      ray           = in_q[0].ray;
      normal        = in_q[0].n;
      v0            = in_q[0].v;
    end else begin
      fifo_in_empty = 1'b1;
      ray           = '0;
      normal        = {3{32'hdead_beef}};
      v0            = {3{32'hbad0_cafe}};
    end
  endtask

  task automatic send(input logic [95:0] o, input logic [95:0] d, input logic [95:0] n,
                      input logic [95:0] v, input logic [96:0] e);
    job_t j;
    j.ray = {d, o};
    j.n   = n;
    j.v   = v;
    in_q.push_back(j);
    exp_q.push_back(e);
    drive_in();
  endtask

  // One clock: sample at the falling edge, act on the FIFO model just after the rising edge.
  task automatic cycle();
    logic [96:0] e;
    @(negedge clock);
    s_rd = fifo_in_rd_en;
    s_wr = fifo_out_wr_en;
    s_p  = p_hit;
    s_m  = miss;
    if (s_rd) begin
      pops++;
      pop_gap  = cyc - last_wr;
      last_pop = cyc;
    end
    if (s_wr) begin
      writes++;
      last_wr = cyc;
      if (exp_q.size() == 0) extra++;
      else begin
        e = exp_q.pop_front();
        chk("result", {s_m, s_p}, e);
      end
    end
    @(posedge clock);
    #1;
    if (s_rd && in_q.size() != 0) void'(in_q.pop_front());
    cyc++;
    drive_in();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
      cycle();
      k++;
    end
    chk("drain", in_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    logic [95:0] pn, pv, n, v, o, d;
    logic [96:0] e1, e2, e6, e;
    int w0, p0, pc, k;

    pn = v3(0, 0, 32'h10000);
    pv = v3(0, 0, 32'h50000);
    e1 = {1'b0, v3(0, 0, 32'h50000)};
    e2 = {1'b0, v3(32'h38000, 32'h20000, 32'h50000)};
    e6 = {1'b0, v3(0, 0, 32'h50000)};

    reset         = 1'b1;
    fifo_out_full = 1'b0;
    drive_in();
    repeat (3) cycle();
    chk("rst_p_hit", s_p, 0);
    chk("rst_miss", s_m, 0);
    chk("rst_wr_en", s_wr, 0);
    chk("rst_rd_en", s_rd, 0);
    reset = 1'b0;
    cycle();

    // Straight-down ray onto z=5
    w0 = writes;
    send(v3(0, 0, 0), v3(0, 0, 32'h10000), pn, pv, e1);
    drain(200);
    chk("hit_latency", last_wr - last_pop, 38);
    chk("hit_wr_count", writes - w0, 1);

    // Oblique ray
    send(v3(32'h10000, 32'h20000, 0), v3(32'h8000, 0, 32'h10000), pn, pv, e2);
    drain(200);

    // Parallel ray
    send(v3(0, 0, 0), v3(32'h10000, 0, 0), pn, pv, {1'b1, 96'b0});
    drain(200);
    chk("miss_latency", last_wr - last_pop, 5);

    // Plane behind, t overflow, origin on plane: back to back
    w0 = writes;
    send(v3(0, 0, 0), v3(0, 0, 32'hFFFF0000), pn, pv, {1'b1, 96'b0});
    send(v3(0, 0, 0), v3(0, 0, 32'h1), pn, pv, {1'b1, 96'b0});
    send(v3(0, 0, 32'h50000), v3(0, 0, 32'h10000), pn, pv, e6);
    drain(300);
    chk("batch_wr_count", writes - w0, 3);
    chk("next_pop_gap", pop_gap, 1);

    // Backpressure at WRITE
    fifo_out_full = 1'b1;
    p0 = pops;
    w0 = writes;
    send(v3(32'h10000, 32'h20000, 0), v3(32'h8000, 0, 32'h10000), pn, pv, e2);
    send(v3(0, 0, 0), v3(0, 0, 32'h10000), pn, pv, e1);
    k = 0;
    while (pops == p0 && k < 10) begin
      cycle();
      k++;
    end
    pc = last_pop;
    while (cyc < pc + 38) cycle();
    repeat (10) begin
      cycle();
      chk("bp_hold_out", {s_m, s_p}, e2);
      chk("bp_hold_wr", s_wr, 0);
    end
    chk("bp_pops", pops - p0, 1);
    fifo_out_full = 1'b0;
    cycle();
    chk("bp_wr_release", s_wr, 1);
    drain(200);
    chk("bp_wr_count", writes - w0, 2);

    // Reset in the middle of the divide
    p0 = pops;
    w0 = writes;
    send(v3(32'h10000, 32'h20000, 0), v3(32'h8000, 0, 32'h10000), pn, pv, e2);
    send(v3(0, 0, 32'h50000), v3(0, 0, 32'h10000), pn, pv, e6);
    k = 0;
    while (pops == p0 && k < 10) begin
      cycle();
      k++;
    end
    pc = last_pop;
    while (cyc < pc + 15) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    cycle();
    chk("mid_rst_p_hit", s_p, 0);
    chk("mid_rst_miss", s_m, 0);
    chk("mid_rst_pop", s_rd, 1);
    drain(200);
    chk("mid_rst_wr_count", writes - w0, 1);

    // Random stream with random downstream stalls; plane changes between rays
    w0 = writes;
    n  = v3(rc(), rc(), rc());
    v  = v3(rc(), rc(), rc());
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        n = v3(rc(), rc(), rc());
        v = v3(rc(), rc(), rc());
      end
      o = v3(rc(), rc(), rc());
      d = v3(rc(), rc(), rc());
      e = model(o, d, n, v);
      send(o, d, n, v, e);
    end
    k = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && k < 40000) begin
      fifo_out_full = ($urandom_range(0, 3) == 0);
      cycle();
      k++;
    end
    fifo_out_full = 1'b0;
    chk("rnd_drain", in_q.size() + exp_q.size(), 0);
    chk("rnd_wr_count", writes - w0, 256);
    chk("spurious_wr", extra, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ray_plane_hit.md
Name: ray_plane_hit

Overview:
Front-end producer for hit_bool. It pops one ray (origin, direction) from an upstream FIFO and intersects it with the triangle's plane, defined by normal and vertex v0. It computes t = n·(v0 − o) / n·d with a serial divider, then p_hit = o + t·d. It writes p_hit plus a miss flag into the downstream FIFO that feeds hit_bool.

Parameters:
Q_BITS, 16, fractional bits of the signed fixed-point format. 32-bit words, Q16.16 by default.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
ray  in  192  FIFO dout. [95:0] origin, [191:96] direction. Each is x=[31:0], y=[63:32], z=[95:64] within its 96-bit half; signed Q(32−Q_BITS).Q_BITS
fifo_in_empty  in  1  upstream FIFO empty (first-word-fall-through: ray valid whenever empty=0)
fifo_in_rd_en  out  1  pop upstream FIFO
normal  in  3x32  plane normal, signed fixed-point, element [0]=x
v0  in  3x32  point on plane, element [0]=x
p_hit  out  96  intersection point, x=[31:0], y=[63:32], z=[95:64]
miss  out  1  1 = no valid forward intersection; p_hit is then forced to 0
fifo_out_full  in  1  downstream FIFO full
fifo_out_wr_en  out  1  push {miss, p_hit} to downstream FIFO

Behaviour:
- Reset: state IDLE. fifo_in_rd_en, fifo_out_wr_en, p_hit and miss all 0. Any ray in flight is discarded. Reset overrides every state, including mid-DIV and mid-WRITE.
- FSM states: IDLE → DOT(3 cycles) → CHECK → DIV(32 cycles) → MUL → WRITE → IDLE. CHECK goes straight to WRITE on a miss.
- IDLE: if !fifo_in_empty, assert fifo_in_rd_en combinationally for 1 cycle. At the same clock edge, capture ray, normal and v0. Later changes to normal or v0 do not affect this ray.
- DOT: one axis per cycle, i = x, y, z.
  - num += n_i·v0_i − n_i·o_i. Products are full 64-bit signed; accumulator is 67-bit signed.
  - den += n_i·d_i, 66-bit signed.
- CHECK: miss if any of the following holds:
  - den == 0 (ray parallel to plane);
  - num ≠ 0 and sign(num) ≠ sign(den) (t < 0, plane behind origin);
  - (|num| << Q_BITS) ≥ (|den| << 31) (|t| does not fit in 31 bits).
  If num == 0, then t = 0, p_hit = origin and miss = 0; this case still goes through DIV/MUL for uniform latency.
- DIV: restoring divide, 1 quotient bit per cycle, MSB first, 32 iterations. Result is t = floor((|num| << Q_BITS) / |den|), a non-negative 32-bit value (bit 31 always 0).
- MUL: for each axis, p_i = o_i + ((t·d_i) >>> Q_BITS).
  - Product is 64-bit signed; the shift is arithmetic (rounds toward −inf).
  - Sum is truncated to 32 bits (wraps, no saturation).
- WRITE: p_hit and miss are registered. fifo_out_wr_en is asserted for exactly one cycle, the first cycle in WRITE with fifo_out_full == 0, then the FSM returns to IDLE. While full, stay in WRITE with outputs stable and no pop upstream.
- Latency, with pop in cycle 0 and full never asserted:
  - hit path: wr_en in cycle 38;
  - miss path: wr_en in cycle 5.
- Throughput: no overlap between rays. The earliest next pop is the cycle after the write.
- p_hit and miss hold their last written value between writes.

Test Plan:
- Plane z=5: normal=(0,0,0x10000), v0=(0,0,0x50000); ray o=(0,0,0), d=(0,0,0x10000) → t=0x50000; p_hit=(0,0,0x50000), miss=0; wr_en exactly 38 cycles after rd_en.
- Same plane; o=(0x10000,0x20000,0), d=(0x8000,0,0x10000) → p_hit=(0x38000,0x20000,0x50000), miss=0.
- Boundary/miss cases:
  - d=(0x10000,0,0) → den=0: miss=1, p_hit=0, wr_en 5 cycles after pop.
  - d=(0,0,0xFFFF0000) → t<0: miss=1.
  - d=(0,0,0x1) → t overflow: miss=1.
  - o=(0,0,0x50000) → num=0: p_hit=origin, miss=0.
- Backpressure: hold fifo_out_full=1 for 10 cycles at WRITE → no wr_en and p_hit stable. Exactly one write follows in the cycle full drops, and no second pop happens while blocked.
- Reset asserted during DIV cycle 10 → outputs 0 next cycle, no write for that ray. The next queued ray pops in the first cycle after reset deasserts and produces the correct result.
- Stream 256 random rays through the upstream FIFO, with the output FIFO feeding hit_bool → every write matches the golden model bit-exactly, in order, with no drops or duplicates.
